framebuffer_writer: RTL and testbench

- Converts a stream of pixel records (x, y, color) from an Avalon-ST sink into single-word Avalon-MM writes into a linear frame buffer in memory.
- Sits between the graphics pixel generators and the memory interconnect. Each accepted pixel produces exactly one write to the pixel's computed address.
- Uses a single-entry output stage, so throughput is one pixel per clock when the slave is not stalling.

---
 rtl/graphics_pkg.sv | 15 +
 rtl/vga_pkg.sv | 7 +
 rtl/framebuffer_writer.sv | 79 +++++++
 tb/tb_framebuffer_writer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics types and memory-bus widths
package graphics_pkg;

  localparam int MM_MEM_ADDR_WIDTH = 32;
  localparam int MM_MEM_DATA_WIDTH = 32;
  localparam int COORD_WIDTH       = 10;
  localparam int COLOR_WIDTH       = 16;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COLOR_WIDTH-1:0] color;
  } pixel_t;

endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - display timing constants shared with the frame buffer
package vga_pkg;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

endpackage

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - pixel stream to single-word frame-buffer writes
// One registered output stage; a stalled write freezes the stream sink.
module framebuffer_writer #(
  parameter int                       MM_ADDR_WIDTH    = graphics_pkg::MM_MEM_ADDR_WIDTH,
  parameter int                       MM_DATA_WIDTH    = graphics_pkg::MM_MEM_DATA_WIDTH,
  parameter logic [MM_ADDR_WIDTH-1:0] MM_START_ADDRESS = '0,
  parameter int                       FB_WIDTH         = vga_pkg::WIDTH,
  parameter int                       CHANNEL_WIDTH    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       st_ready,
  input  graphics_pkg::pixel_t       st_data,
  input  logic [CHANNEL_WIDTH-1:0]   st_channel,
  input  logic                       st_valid,
  output logic                       mm_write,
  output logic [MM_ADDR_WIDTH-1:0]   mm_address,
  output logic [MM_DATA_WIDTH-1:0]   mm_writedata,
  input  logic                       mm_waitrequest
);

  localparam int BYTES_PER_WORD = MM_DATA_WIDTH / 8;
  localparam int COLOR_W        = $bits(st_data.color);

  logic                     mm_write_q, mm_write_d;
  logic [MM_ADDR_WIDTH-1:0] mm_address_q, mm_address_d;
  logic [MM_DATA_WIDTH-1:0] mm_writedata_q, mm_writedata_d;

  logic [63:0]              pix_index;
  logic [63:0]              byte_offset;
  logic [MM_DATA_WIDTH-1:0] color_word;
  logic                     unused_channel;

  assign unused_channel = ^st_channel;

  // Index is formed at 64 bits so y*FB_WIDTH + x never overflows before truncation.
  assign pix_index   = 64'(st_data.y) * 64'(FB_WIDTH) + 64'(st_data.x);
  assign byte_offset = pix_index * 64'(BYTES_PER_WORD);

  generate
    if (COLOR_W >= MM_DATA_WIDTH) begin : g_color_trunc
      assign color_word = st_data.color[MM_DATA_WIDTH-1:0];
    end else begin : g_color_ext
      assign color_word = {{(MM_DATA_WIDTH-COLOR_W){1'b0}}, st_data.color};
    end
  endgenerate

  assign st_ready = !mm_write_q || !mm_waitrequest;

  always_comb begin
    mm_write_d     = mm_write_q;
    mm_address_d   = mm_address_q;
    mm_writedata_d = mm_writedata_q;
    if (st_ready) begin
      mm_write_d = st_valid;
      if (st_valid) begin
        mm_address_d   = MM_START_ADDRESS + byte_offset[MM_ADDR_WIDTH-1:0];
        mm_writedata_d = color_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mm_write_q     <= 1'b0;
      mm_address_q   <= '0;
      mm_writedata_q <= '0;
    end else begin
      mm_write_q     <= mm_write_d;
      mm_address_q   <= mm_address_d;
      mm_writedata_q <= mm_writedata_d;
    end
  end

  assign mm_write     = mm_write_q;
  assign mm_address   = mm_address_q;
  assign mm_writedata = mm_writedata_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - directed self-checking bench for framebuffer_writer
module tb_framebuffer_writer;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 st_ready;
  graphics_pkg::pixel_t st_data = '0;
  logic [0:0]           st_channel = 1'b0;
  logic                 st_valid = 1'b0;
  logic                 mm_write;
  logic [31:0]          mm_address;
  logic [31:0]          mm_writedata;
  logic                 mm_waitrequest = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  framebuffer_writer #(
    .MM_ADDR_WIDTH    (32),
    .MM_DATA_WIDTH    (32),
    .MM_START_ADDRESS (32'd1000),
    .FB_WIDTH         (640),
    .CHANNEL_WIDTH    (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .st_ready       (st_ready),
    .st_data        (st_data),
    .st_channel     (st_channel),
    .st_valid       (st_valid),
    .mm_write       (mm_write),
    .mm_address     (mm_address),
    .mm_writedata   (mm_writedata),
    .mm_waitrequest (mm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int color);
    st_data.x     = 10'(x);
    st_data.y     = 10'(y);
    st_data.color = 16'(color);
    st_valid      = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; st_valid = 1'b0; mm_waitrequest = 1'b0;
    step();
    n_cmp++; if (mm_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b want=0", mm_write); end
    n_cmp++; if (mm_address !== 32'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", mm_address); end
    n_cmp++; if (mm_writedata !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%0d want=0", mm_writedata); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", st_ready); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (mm_write !== 1'b0) begin n_fail++; $display("FAIL idle_write[%0d] got=%b want=0", i, mm_write); end
      n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready[%0d] got=%b want=1", i, st_ready); end
    end
  endtask

  task automatic test_single();
    send(10, 2, 15);
    step();
    st_valid = 1'b0;
    n_cmp++; if (mm_write !== 1'b1) begin n_fail++; $display("FAIL single_write got=%b want=1", mm_write); end
    n_cmp++; if (mm_address !== 32'd6160) begin n_fail++; $display("FAIL single_addr got=%0d want=6160", mm_address); end
    n_cmp++; if (mm_writedata !== 32'd15) begin n_fail++; $display("FAIL single_data got=%0d want=15", mm_writedata); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b want=1", st_ready); end
    step();
    n_cmp++; if (mm_write !== 1'b0) begin n_fail++; $display("FAIL single_drain_write got=%b want=0", mm_write); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL single_drain_ready got=%b want=1", st_ready); end
  endtask

  task automatic test_back_to_back_stall();
    send(10, 2, 15);
    step();
    n_cmp++; if (mm_write !== 1'b1 || mm_address !== 32'd6160 || mm_writedata !== 32'd15) begin
      n_fail++; $display("FAIL b2b_first got=%b/%0d/%0d want=1/6160/15", mm_write, mm_address, mm_writedata); end
    send(3, 1, 20);
    step();
    n_cmp++; if (mm_write !== 1'b1 || mm_address !== 32'd3572 || mm_writedata !== 32'd20) begin
      n_fail++; $display("FAIL b2b_second got=%b/%0d/%0d want=1/3572/20", mm_write, mm_address, mm_writedata); end
    send(1, 5, 50);
    mm_waitrequest = 1'b1;
    #1;
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_comb got=%b want=0", st_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (mm_write !== 1'b1 || mm_address !== 32'd3572 || mm_writedata !== 32'd20) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%b/%0d/%0d want=1/3572/20", i, mm_write, mm_address, mm_writedata); end
      n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b want=0", i, st_ready); end
    end
    mm_waitrequest = 1'b0;
    #1;
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready got=%b want=1", st_ready); end
    step();
    st_valid = 1'b0;
    n_cmp++; if (mm_write !== 1'b1 || mm_address !== 32'd13804 || mm_writedata !== 32'd50) begin
      n_fail++; $display("FAIL after_stall got=%b/%0d/%0d want=1/13804/50", mm_write, mm_address, mm_writedata); end
    step();
    n_cmp++; if (mm_write !== 1'b0 || st_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain got=%b/%b want write=0 ready=1", mm_write, st_ready); end
    n_cmp++; if (mm_address !== 32'd13804 || mm_writedata !== 32'd50) begin
      n_fail++; $display("FAIL drain_hold got=%0d/%0d want=13804/50", mm_address, mm_writedata); end
  endtask

  task automatic test_boundary();
    send(1023, 1023, 16'hFFFF);
    st_channel = 1'b1;
    step();
    st_valid = 1'b0;
    n_cmp++; if (mm_address !== 32'd2623972) begin n_fail++; $display("FAIL max_coord_addr got=%0d want=2623972", mm_address); end
    n_cmp++; if (mm_writedata !== 32'h0000FFFF) begin n_fail++; $display("FAIL color_zero_ext got=%h want=0000ffff", mm_writedata); end
    send(0, 0, 1);
    step();
    st_valid = 1'b0; st_channel = 1'b0;
    n_cmp++; if (mm_write !== 1'b1 || mm_address !== 32'd1000 || mm_writedata !== 32'd1) begin
      n_fail++; $display("FAIL origin got=%b/%0d/%0d want=1/1000/1", mm_write, mm_address, mm_writedata); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    send(7, 0, 99);
    step();
    n_cmp++; if (mm_write !== 1'b1 || mm_address !== 32'd1028) begin
      n_fail++; $display("FAIL pre_reset got=%b/%0d want=1/1028", mm_write, mm_address); end
    send(8, 0, 77);
    mm_waitrequest = 1'b1;
    reset = 1'b1;
    step();
    n_cmp++; if (mm_write !== 1'b0 || mm_address !== 32'd0 || mm_writedata !== 32'd0) begin
      n_fail++; $display("FAIL mid_stall_reset got=%b/%0d/%0d want=0/0/0", mm_write, mm_address, mm_writedata); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high got=%b want=1", st_ready); end
    reset = 1'b0; st_valid = 1'b0; mm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (mm_write !== 1'b0) begin n_fail++; $display("FAIL dropped_write[%0d] got=%b want=0", i, mm_write); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back_stall();
    test_boundary();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
